// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry show-ahead FIFO between fetch and decode.
// Carries {pc, inst, exc_code, badvaddr} per entry. A pushed exception
// fences further fetches until flush. Flush empties the queue.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_inst,
  input  logic [EXC_W-1:0]  if_exc_code,
  input  logic [DATA_W-1:0] if_exc_badvaddr,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic [EXC_W-1:0]  id_exc_code,
  output logic [DATA_W-1:0] id_exc_badvaddr,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [EXC_W-1:0]  exc_code;
    logic [DATA_W-1:0] badvaddr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             fence;
  logic             full, empty, push, pop;
  entry_t           wr_ent, head;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  // Registered state only: no combinational path from id_stall.
  assign if_ready = !full && !fence;
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && !id_stall && !flush;
  assign id_valid = !empty;

  assign wr_ent = '{pc: if_pc, inst: if_inst, exc_code: if_exc_code,
                    badvaddr: if_exc_badvaddr};

  // Empty queue presents an all-zero entry (nop, EC_None).
  assign head            = empty ? '0 : mem[rd_ptr];
  assign id_pc           = head.pc;
  assign id_inst         = head.inst;
  assign id_exc_code     = head.exc_code;
  assign id_exc_badvaddr = head.badvaddr;

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  // Pointer, occupancy and fence control; flush overrides push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fence  <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fence  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (if_exc_code != '0) fence <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int EW    = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          if_valid = 1'b0;
  logic          if_ready;
  logic [DW-1:0] if_pc = '0, if_inst = '0, if_exc_badvaddr = '0;
  logic [EW-1:0] if_exc_code = '0;
  logic          id_stall = 1'b1;
  logic          id_valid;
  logic [DW-1:0] id_pc, id_inst, id_exc_badvaddr;
  logic [EW-1:0] id_exc_code;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
    logic [EW-1:0] exc;
    logic [DW-1:0] bad;
  } ent_t;

  ent_t mq[$];
  bit   mfence = 0;

  if_id_queue #(.DEPTH(DEPTH), .DATA_W(DW), .EXC_W(EW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_exc_code(if_exc_code), .if_exc_badvaddr(if_exc_badvaddr),
    .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_exc_code(id_exc_code), .id_exc_badvaddr(id_exc_badvaddr), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // One clock cycle: drive inputs, advance the reference model by the
  // queue rules (ready = room and no fence; flush wins), sample after edge.
  task automatic cyc(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] inst,
                     input logic [EW-1:0] exc, input logic [DW-1:0] bad,
                     input logic st, input logic fl);
    bit   rdy, psh, pp;
    ent_t e;
    if_valid = v; if_pc = pc; if_inst = inst; if_exc_code = exc;
    if_exc_badvaddr = bad; id_stall = st; flush = fl;
    rdy = (mq.size() < DEPTH) && !mfence;
    psh = v && rdy && !fl;
    pp  = (mq.size() > 0) && !st && !fl;
    @(posedge clk); #1;
    if (fl) begin
      mq.delete();
      mfence = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (psh) begin
        e.pc = pc; e.inst = inst; e.exc = exc; e.bad = bad;
        mq.push_back(e);
        if (exc != 0) mfence = 1;
      end
    end
    if_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({id_valid, count, id_pc, id_inst, id_exc_code, id_exc_badvaddr, if_ready} !==
        {1'b0, CW'(0), DW'(0), DW'(0), EW'(0), DW'(0), 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs valid=%b count=%0d pc=%h ready=%b want 0/0/0/1",
               id_valid, count, id_pc, if_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", if_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 4*i, 32'hA000 + i, 0, 0, 1, 0);
    checks++;
    if ({count, if_ready, id_pc} !== {CW'(4), 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL fill count=%0d ready=%b pc=%h want 4/0/100", count, if_ready, id_pc);
    end
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h100 + 32'(4*i), 32'hA000 + 32'(i)}) begin
        errors++;
        $display("FAIL drain_%0d valid=%b pc=%h inst=%h want pc %h", i, id_valid, id_pc,
                 id_inst, 32'h100 + 4*i);
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({id_valid, count, id_pc, id_inst, id_exc_code, id_exc_badvaddr} !== '0) begin
      errors++;
      $display("FAIL drain_empty valid=%b count=%0d pc=%h inst=%h want zeros",
               id_valid, count, id_pc, id_inst);
    end
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 12; k++) begin
      cyc(1, 32'h300 + 4*k, 32'hB000 + k, 0, 0, 0, 0);
      checks++;
      if ({id_valid, count, id_pc} !== {1'b1, CW'(1), 32'h300 + 32'(4*k)}) begin
        errors++;
        $display("FAIL stream_%0d valid=%b count=%0d pc=%h want 1/1/%h", k, id_valid,
                 count, id_pc, 32'h300 + 4*k);
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) cyc(1, 32'h400 + 4*i, 0, 0, 0, 1, 0);
    checks++;
    if (if_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b want 0", if_ready);
    end
    cyc(1, 32'h4FF0, 0, 0, 0, 0, 0);
    checks++;
    if ({count, id_pc} !== {CW'(3), 32'h404}) begin
      errors++;
      $display("FAIL full_pop count=%0d pc=%h want 3/404", count, id_pc);
    end
    for (int i = 2; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({id_valid, id_pc} !== {1'b1, 32'h40C}) begin
      errors++;
      $display("FAIL full_pop_tail valid=%b pc=%h want 1/40C", id_valid, id_pc);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_dropped valid=%b pc=%h want empty", id_valid, id_pc);
    end
  endtask

  task automatic test_flush();
    cyc(1, 32'h500, 32'hC0, 0, 0, 1, 0);
    cyc(1, 32'h504, 32'hC1, 0, 0, 1, 0);
    cyc(1, 32'h508, 32'hC2, 0, 0, 0, 1);
    checks++;
    if ({count, id_valid, id_inst, if_ready} !== {CW'(0), 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL flush count=%0d valid=%b inst=%h ready=%b want 0/0/0/1",
               count, id_valid, id_inst, if_ready);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop valid=%b pc=%h want empty", id_valid, id_pc);
    end
  endtask

  task automatic test_fence();
    cyc(1, 32'h200, 32'hD0, 0, 0, 1, 0);
    cyc(1, 32'h204, 32'hD1, 4, 32'h205, 1, 0);
    checks++;
    if (if_ready !== 1'b0) begin
      errors++;
      $display("FAIL fence_ready got %b want 0", if_ready);
    end
    cyc(1, 32'h208, 32'hD2, 0, 0, 1, 0);
    checks++;
    if ({count, id_pc, id_exc_code} !== {CW'(2), 32'h200, EW'(0)}) begin
      errors++;
      $display("FAIL fence_head count=%0d pc=%h exc=%0d want 2/200/0", count, id_pc,
               id_exc_code);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({id_pc, id_exc_code, id_exc_badvaddr} !== {32'h204, EW'(4), 32'h205}) begin
      errors++;
      $display("FAIL fence_exc pc=%h exc=%0d bad=%h want 204/4/205", id_pc, id_exc_code,
               id_exc_badvaddr);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({id_valid, if_ready} !== 2'b00) begin
      errors++;
      $display("FAIL fence_drained valid=%b ready=%b want 0/0", id_valid, if_ready);
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (if_ready !== 1'b1) begin
      errors++;
      $display("FAIL fence_flush ready=%b want 1", if_ready);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] epc, einst, ebad;
    logic [EW-1:0] eexc;
    bit            erdy;
    for (int n = 0; n < 400; n++) begin
      erdy = (mq.size() < DEPTH) && !mfence;
      checks++;
      if (if_ready !== erdy) begin
        errors++;
        $display("FAIL rand_ready_%0d got %b want %b", n, if_ready, erdy);
      end
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom,
          ($urandom_range(0, 24) == 0) ? EW'($urandom_range(1, 31)) : EW'(0),
          $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
      if (mq.size() > 0) begin
        epc = mq[0].pc; einst = mq[0].inst; eexc = mq[0].exc; ebad = mq[0].bad;
      end else begin
        epc = '0; einst = '0; eexc = '0; ebad = '0;
      end
      checks++;
      if ({id_valid, count, id_pc, id_inst, id_exc_code, id_exc_badvaddr} !==
          {mq.size() > 0, CW'(mq.size()), epc, einst, eexc, ebad}) begin
        errors++;
        $display("FAIL rand_out_%0d valid=%b count=%0d pc=%h inst=%h exc=%0d want count=%0d pc=%h inst=%h exc=%0d",
                 n, id_valid, count, id_pc, id_inst, id_exc_code, mq.size(), epc, einst, eexc);
      end
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cyc(1, 32'h600 + 4*i, 32'hE0 + i, 0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({id_valid, count, id_pc, id_inst, id_exc_code, id_exc_badvaddr, if_ready} !==
        {1'b0, CW'(0), DW'(0), DW'(0), EW'(0), DW'(0), 1'b1}) begin
      errors++;
      $display("FAIL async_reset valid=%b count=%0d pc=%h ready=%b want 0/0/0/1",
               id_valid, count, id_pc, if_ready);
    end
    mq.delete();
    mfence = 0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({id_valid, count} !== {1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL async_reset_after valid=%b count=%0d want 0/0", id_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_flush();
    test_fence();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction queue between fetch (IF) and decode (ID) stages. It replaces the single-entry IF/ID pipeline register with a DEPTH-entry FIFO and a valid/ready handshake on the fetch side. It carries PC, instruction word and fetch-stage exception information per entry. Flush discards all entries. A fetched exception fences further fetches until the next flush.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- DATA_W, 32: PC and instruction width.
- EXC_W, 5: exception code width; code 0 means EC_None.
- CNT_W, $clog2(DEPTH+1): occupancy counter width.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; priority over push and pop.
- if_valid  in  1  fetch presents an entry.
- if_ready  out  1  queue accepts an entry this cycle.
- if_pc  in  DATA_W  fetch PC.
- if_inst  in  DATA_W  fetched instruction.
- if_exc_code  in  EXC_W  fetch exception code.
- if_exc_badvaddr  in  DATA_W  fetch bad virtual address.
- id_stall  in  1  1 = decode is not consuming this cycle.
- id_valid  out  1  head entry is valid.
- id_pc  out  DATA_W  head PC; 0 when empty.
- id_inst  out  DATA_W  head instruction; 0 (nop) when empty.
- id_exc_code  out  EXC_W  head exception code; 0 when empty.
- id_exc_badvaddr  out  DATA_W  head bad address; 0 when empty.
- count  out  CNT_W  current occupancy.

## Operation
- Storage: DEPTH-entry circular buffer. Each entry holds {pc, inst, exc_code, badvaddr}.
- Pointers: read and write pointers, each log2(DEPTH) bits. Both wrap modulo DEPTH.
- Occupancy: count register, range 0..DEPTH.
- Flags: full = (count == DEPTH); empty = (count == 0).
- Fence: `fence` register, set when an entry with exc_code != 0 is pushed.
- if_ready = !full && !fence. It is a pure function of registered state, with no path from id_stall.
- push = if_valid && if_ready && !flush.
- pop = id_valid && !id_stall && !flush.
- id_valid = !empty.
- id_* outputs: when non-empty, they show the head entry (show-ahead). When empty, they are forced to all zeros.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any non-full occupancy.
- When full, if_ready = 0 even if a pop occurs in the same cycle. No push-through when full.
- Flush: pointers ← 0, count ← 0, fence ← 0. A same-cycle push is dropped and a same-cycle pop has no effect.
- Fence clears only on flush or reset. Entries already queued behind the exception entry drain normally.
- Reset (rst=0, asynchronous): pointers, count and fence ← 0. Storage contents are don't-care.
- Reset output values: id_valid=0, all id_* = 0, count=0, if_ready=1.
- No other state machine exists. Queue state is fully described by (count, rd_ptr, wr_ptr, fence).

## Timing
- Write-to-read latency: 1 cycle. An entry pushed at edge N appears on id_* after edge N, even when the queue was empty.
- A pop at edge N exposes the next entry (or zeros) immediately after edge N.
- A flush asserted in cycle N gives, after edge N: id_valid=0, count=0, if_ready=1.
- Reset release gives if_ready=1 with no cycle of delay.
- Sustained throughput: 1 entry per cycle whenever 0 < count < DEPTH and id_stall=0.

## Test plan
- **Fill/drain:** DEPTH=4. Push PCs 0x100, 0x104, 0x108, 0x10C with id_stall=1. Required: count=4, if_ready=0, id_pc=0x100. Then set id_stall=0. Required: id_pc steps 0x104, 0x108, 0x10C, then id_valid=0 with all id_* = 0.
- **Streaming:** push one entry per cycle for 12 cycles with id_stall=0. Required: no bubbles after the first entry, count stays 1, and PCs emerge in order across pointer wrap.
- **Full with pop:** count=4, then if_valid=1 and id_stall=0. Required: if_ready=0, no push, count=3 next cycle.
- **Flush priority:** count=2, then assert flush together with if_valid=1 and id_stall=0. Required next cycle: count=0, id_valid=0, id_inst=0, if_ready=1, and the pushed entry is absent.
- **Exception fence:** push 0x200 (exc 0), then 0x204 with exc_code=4 and badvaddr=0x205. Required: if_ready=0 afterwards. Both entries drain with exc fields intact, and if_ready returns to 1 only after flush.
- **Async reset:** count=3, then drive rst=0 mid-cycle. Required, immediately and without waiting for a clock edge: id_valid=0, all id_* = 0, count=0, if_ready=1.
